// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// instruction memory (slave). Read data is combinational on the address.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 11
);
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  imem_valid;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the RV32I pipeline: PC register, next-PC
// selection (sequential or execute redirect), instruction-memory request and
// the IF/ID pipeline register with stall, flush and wait-state bubbles.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_WIDTH   = 11,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h00000013)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall_f,
  input  logic                  i_stall_d,
  input  logic                  i_flush_d,
  input  logic                  i_pcsrc_e,
  input  logic [PC_WIDTH-1:0]   i_pctarget_e,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] o_instr_d,
  output logic [PC_WIDTH-1:0]   o_pc_d,
  output logic [PC_WIDTH-1:0]   o_pc4_d,
  output logic                  o_valid_d
);

  // Low two bits are cleared so the PC can never become misaligned.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK   = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] RESET_PC_ALN = RESET_PC & ALIGN_MASK;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] target_aln;

  // Sequential increment wraps naturally at the top of the address space.
  assign pc_plus4   = pc_q + PC_WIDTH'(4);
  assign target_aln = i_pctarget_e & ALIGN_MASK;

  // Memory sees the PC register directly; a request is made whenever out of reset.
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = i_rst_n;

  // PC update: redirect beats stall and wait; otherwise advance only on a completed fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q <= RESET_PC_ALN;
    end else if (i_pcsrc_e) begin
      pc_q <= target_aln;
    end else if (!i_stall_f && imem.imem_valid) begin
      pc_q <= pc_plus4;
    end
  end

  // IF/ID register: flush beats stall; a memory wait loads a bubble so the PC refetches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instr_d <= NOP_INSTR;
      o_pc_d    <= '0;
      o_pc4_d   <= '0;
      o_valid_d <= 1'b0;
    end else if (i_flush_d) begin
      o_instr_d <= NOP_INSTR;
      o_pc_d    <= '0;
      o_pc4_d   <= '0;
      o_valid_d <= 1'b0;
    end else if (i_stall_d) begin
      o_instr_d <= o_instr_d;
      o_pc_d    <= o_pc_d;
      o_pc4_d   <= o_pc4_d;
      o_valid_d <= o_valid_d;
    end else if (!imem.imem_valid) begin
      o_instr_d <= NOP_INSTR;
      o_pc_d    <= '0;
      o_pc4_d   <= '0;
      o_valid_d <= 1'b0;
    end else begin
      o_instr_d <= imem.imem_rdata;
      o_pc_d    <= pc_q;
      o_pc4_d   <= pc_plus4;
      o_valid_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with an address-tagged instruction
// memory, a spec-level behavioural model checked every cycle, and literal
// expectations at key points of the sequence.
module tb_fetch_stage;

  localparam int DW = 32;
  localparam int PW = 11;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] TAG = 32'hC0DE0000;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_stall_f;
  logic          i_stall_d;
  logic          i_flush_d;
  logic          i_pcsrc_e;
  logic [PW-1:0] i_pctarget_e;
  logic          mem_valid;
  logic [DW-1:0] o_instr_d;
  logic [PW-1:0] o_pc_d;
  logic [PW-1:0] o_pc4_d;
  logic          o_valid_d;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state (plain integers, byte addresses)
  int          m_pc    = 0;
  logic [31:0] m_instr = NOP;
  int          m_pcd   = 0;
  int          m_pc4d  = 0;
  logic        m_vd    = 1'b0;

  fetch_stage_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) imem_bus ();

  // Instruction memory: each word is its own byte address tagged with C0DE.
  assign imem_bus.imem_rdata = TAG | {21'b0, imem_bus.imem_addr};
  assign imem_bus.imem_valid = mem_valid;

  fetch_stage #(
    .DATA_WIDTH(DW),
    .PC_WIDTH  (PW),
    .RESET_PC  (11'h000),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_stall_f   (i_stall_f),
    .i_stall_d   (i_stall_d),
    .i_flush_d   (i_flush_d),
    .i_pcsrc_e   (i_pcsrc_e),
    .i_pctarget_e(i_pctarget_e),
    .imem        (imem_bus.master),
    .o_instr_d   (o_instr_d),
    .o_pc_d      (o_pc_d),
    .o_pc4_d     (o_pc4_d),
    .o_valid_d   (o_valid_d)
  );

  // Free-running clock, period 10
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single comparison: counts every call and reports any difference.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs, let one rising edge happen, return just after the falling edge.
  task automatic apply_stimulus(input logic sf, input logic sd, input logic fl,
                                input logic pcs, input logic [PW-1:0] tgt,
                                input logic v);
    i_stall_f    = sf;
    i_stall_d    = sd;
    i_flush_d    = fl;
    i_pcsrc_e    = pcs;
    i_pctarget_e = tgt;
    mem_valid    = v;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
  endtask

  // Model of the fetch stage rules: the word at PC is what gets fetched,
  // advancing needs a completed fetch, a redirect lands on the aligned target.
  always @(posedge i_clk or negedge i_rst_n) begin
    int cur;
    if (!i_rst_n) begin
      m_pc = 0; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_vd = 1'b0;
    end else begin
      cur = m_pc;
      if (i_flush_d || (!i_stall_d && !mem_valid)) begin
        m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_vd = 1'b0;
      end else if (!i_stall_d) begin
        m_instr = TAG | 32'(cur);
        m_pcd   = cur;
        m_pc4d  = (cur + 4) % 2048;
        m_vd    = 1'b1;
      end
      if (i_pcsrc_e)
        m_pc = (int'(i_pctarget_e) / 4) * 4;
      else if (!i_stall_f && mem_valid)
        m_pc = (cur + 4) % 2048;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    check_output("m_addr",  32'(imem_bus.imem_addr), 32'(m_pc));
    check_output("m_req",   32'(imem_bus.imem_req),  32'(i_rst_n));
    check_output("m_instr", o_instr_d,               m_instr);
    check_output("m_pc_d",  32'(o_pc_d),             32'(m_pcd));
    check_output("m_pc4_d", 32'(o_pc4_d),            32'(m_pc4d));
    check_output("m_valid", 32'(o_valid_d),          32'(m_vd));
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    i_stall_f = 1'b0; i_stall_d = 1'b0; i_flush_d = 1'b0;
    i_pcsrc_e = 1'b0; i_pctarget_e = '0; mem_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    // Reset values
    check_output("rst_addr",  32'(imem_bus.imem_addr), 32'h000);
    check_output("rst_req",   32'(imem_bus.imem_req),  32'h0);
    check_output("rst_instr", o_instr_d,               NOP);
    check_output("rst_pc_d",  32'(o_pc_d),             32'h0);
    check_output("rst_valid", 32'(o_valid_d),          32'h0);
    i_rst_n = 1'b1;
    #1;
    check_output("rel_req", 32'(imem_bus.imem_req), 32'h1);

    // Free run
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("run_addr",  32'(imem_bus.imem_addr), 32'h004);
    check_output("run_instr", o_instr_d,               32'hC0DE0000);
    check_output("run_pc4",   32'(o_pc4_d),            32'h004);
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("run_addr2", 32'(imem_bus.imem_addr), 32'h008);

    // Load-use stall at PC 0x008
    apply_stimulus(1, 1, 0, 0, 11'h0, 1);
    check_output("stall_addr", 32'(imem_bus.imem_addr), 32'h008);
    check_output("stall_pc_d", 32'(o_pc_d),             32'h004);
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("resume_pc_d", 32'(o_pc_d), 32'h008);

    // Memory wait for three cycles at PC 0x00C
    repeat (3) apply_stimulus(0, 0, 0, 0, 11'h0, 0);
    check_output("wait_addr",  32'(imem_bus.imem_addr), 32'h00C);
    check_output("wait_instr", o_instr_d,               NOP);
    check_output("wait_valid", 32'(o_valid_d),          32'h0);
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("wait_done_instr", o_instr_d, 32'hC0DE000C);

    // Redirect at PC 0x010 to unaligned 0x123
    apply_stimulus(0, 0, 0, 1, 11'h123, 1);
    check_output("redir_addr", 32'(imem_bus.imem_addr), 32'h120);
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("redir_instr", o_instr_d,    32'hC0DE0120);
    check_output("redir_pc4",   32'(o_pc4_d), 32'h124);

    // Redirect with IF/ID stalled, then redirect during a memory wait
    apply_stimulus(0, 1, 0, 1, 11'h200, 1);
    check_output("rs_addr", 32'(imem_bus.imem_addr), 32'h200);
    check_output("rs_pc_d", 32'(o_pc_d),             32'h120);
    apply_stimulus(0, 0, 0, 1, 11'h300, 0);
    check_output("rw_addr",  32'(imem_bus.imem_addr), 32'h300);
    check_output("rw_valid", 32'(o_valid_d),          32'h0);

    // PC stall alone still loads IF/ID
    apply_stimulus(1, 0, 0, 0, 11'h0, 1);
    check_output("sf_addr", 32'(imem_bus.imem_addr), 32'h300);
    check_output("sf_pc_d", 32'(o_pc_d),             32'h300);

    // Flush together with stall gives a bubble
    apply_stimulus(0, 1, 1, 0, 11'h0, 1);
    check_output("fs_instr", o_instr_d,       NOP);
    check_output("fs_valid", 32'(o_valid_d),  32'h0);
    check_output("fs_addr",  32'(imem_bus.imem_addr), 32'h304);

    // Wrap at the top of the address space
    apply_stimulus(0, 0, 0, 1, 11'h7FE, 1);
    check_output("wrap_addr", 32'(imem_bus.imem_addr), 32'h7FC);
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("wrap_addr2", 32'(imem_bus.imem_addr), 32'h000);
    check_output("wrap_pc_d",  32'(o_pc_d),             32'h7FC);
    check_output("wrap_pc4",   32'(o_pc4_d),            32'h000);

    // Asynchronous reset in the middle of a wait
    apply_stimulus(0, 0, 0, 0, 11'h0, 0);
    apply_stimulus(0, 0, 0, 0, 11'h0, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_output("arst_addr",  32'(imem_bus.imem_addr), 32'h000);
    check_output("arst_req",   32'(imem_bus.imem_req),  32'h0);
    check_output("arst_instr", o_instr_d,               NOP);
    check_output("arst_pc4",   32'(o_pc4_d),            32'h0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("post_pc_d",  32'(o_pc_d),    32'h000);
    check_output("post_valid", 32'(o_valid_d), 32'h1);
    apply_stimulus(0, 0, 0, 0, 11'h0, 1);
    check_output("post_addr", 32'(imem_bus.imem_addr), 32'h008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
